spi_boot_seq: RTL and testbench

SPI_BOOT_SEQ -- requirements
Module: spi_boot_seq

---
 rtl/spi_boot_seq_pkg.sv | 31 +++
 rtl/spi_boot_seq_if.sv | 78 +++++++
 rtl/spi_boot_seq_timeout_cnt.sv | 45 ++++
 rtl/spi_boot_seq.sv | 195 +++++++++++++++++++
 tb/tb_spi_boot_seq.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_boot_seq_pkg.sv
// -----------------------------------------------------------------------------
// spi_boot_pkg
// Shared definitions for the SPI boot sequencer:
//   - state_e      : sequencer state encoding
//   - DEF_AW       : default word-address width
//   - DEF_WORDS    : default number of 32-bit words per boot image
//   - DEF_BASE     : default first flash word address
//   - DEF_TIMEOUT  : default per-word fetch timeout in cycles
// -----------------------------------------------------------------------------
package spi_boot_pkg;

    localparam int DEF_AW      = 10;
    localparam int DEF_WORDS   = 256;
    localparam int DEF_BASE    = 0;
    localparam int DEF_TIMEOUT = 1000;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4,
        ST_ERR   = 3'd5
    } state_e;

    // True for the states in which a boot is actively in progress.
    function automatic logic is_busy_state(input state_e s);
        return (s == ST_ISSUE) || (s == ST_WAIT) || (s == ST_WRITE);
    endfunction

endpackage

// File: rtl/spi_boot_seq_if.sv
// -----------------------------------------------------------------------------
// spi_boot_seq_if
// Bundles the control, fetch-engine and program-RAM signals of the boot
// sequencer.
//   slave  : the sequencer side (consumes i_*, drives o_*)
//   master : the surrounding system (drives i_*, consumes o_*)
// Signals:
//   i_boot_req    start/restart boot (1-cycle pulse)
//   i_abort       abandon the boot in progress
//   i_fetch_busy  fetch engine occupied
//   i_word_valid  fetched word present this cycle
//   i_word_data   fetched word
//   o_fetch_start single-cycle fetch request
//   o_fetch_addr  flash word address, valid with o_fetch_start
//   o_mem_we      program RAM write strobe
//   o_mem_addr    program RAM word address
//   o_mem_wdata   program RAM write data
//   o_cpu_rst_n   CPU reset, active low
//   o_busy        boot in progress
//   o_done        image fully loaded
//   o_err         fetch timeout occurred
// -----------------------------------------------------------------------------
interface spi_boot_seq_if
    import spi_boot_pkg::*;
#(
    parameter int AW = DEF_AW
);

    logic          i_boot_req;
    logic          i_abort;
    logic          i_fetch_busy;
    logic          i_word_valid;
    logic [31:0]   i_word_data;
    logic          o_fetch_start;
    logic [AW-1:0] o_fetch_addr;
    logic          o_mem_we;
    logic [AW-1:0] o_mem_addr;
    logic [31:0]   o_mem_wdata;
    logic          o_cpu_rst_n;
    logic          o_busy;
    logic          o_done;
    logic          o_err;

    modport slave (
        input  i_boot_req,
        input  i_abort,
        input  i_fetch_busy,
        input  i_word_valid,
        input  i_word_data,
        output o_fetch_start,
        output o_fetch_addr,
        output o_mem_we,
        output o_mem_addr,
        output o_mem_wdata,
        output o_cpu_rst_n,
        output o_busy,
        output o_done,
        output o_err
    );

    modport master (
        output i_boot_req,
        output i_abort,
        output i_fetch_busy,
        output i_word_valid,
        output i_word_data,
        input  o_fetch_start,
        input  o_fetch_addr,
        input  o_mem_we,
        input  o_mem_addr,
        input  o_mem_wdata,
        input  o_cpu_rst_n,
        input  o_busy,
        input  o_done,
        input  o_err
    );

endinterface

// File: rtl/spi_boot_seq_timeout_cnt.sv
// -----------------------------------------------------------------------------
// boot_timeout_cnt
// 16-bit per-word timeout counter.
//   clk       clock, rising edge
//   rst       asynchronous, active-low reset (count -> 0)
//   clr_i     synchronous clear (wins over en_i)
//   en_i      count one cycle
//   expired_o count has reached LIMIT
// The count saturates at LIMIT so a stalled enable cannot wrap around.
// -----------------------------------------------------------------------------
module boot_timeout_cnt
    import spi_boot_pkg::*;
#(
    parameter logic [15:0] LIMIT = 16'(DEF_TIMEOUT - 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    logic [15:0] count_q;
    logic [15:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i && (count_q != LIMIT)) begin
            count_d = count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = (count_q == LIMIT);

endmodule

// File: rtl/spi_boot_seq.sv
// -----------------------------------------------------------------------------
// spi_boot_seq
// Copies a boot image of WORDS 32-bit words from flash (through an external
// fetch engine) into program RAM, then releases the CPU from reset.
// Parameters:
//   AW       word-address width
//   WORDS    words per image (2..2^AW)
//   BASE     first flash word address
//   TIMEOUT  maximum cycles to wait for one word (2..65535)
// Ports:
//   clk      clock, rising edge
//   rst      asynchronous, active-low reset
//   bus      spi_boot_seq_if.slave (control, fetch engine, program RAM)
// Timing: every output is a register.  A fetch request is visible in the
// first WAIT cycle; the RAM write strobe for a word is visible in the cycle
// after its WRITE state, so an abort seen during WRITE can still cancel it.
// Status outputs (busy/err) follow the state; done and the CPU reset release
// appear one cycle after the final write strobe.
// -----------------------------------------------------------------------------
module spi_boot_seq
    import spi_boot_pkg::*;
#(
    parameter int            AW      = DEF_AW,
    parameter int            WORDS   = DEF_WORDS,
    parameter logic [AW-1:0] BASE    = AW'(DEF_BASE),
    parameter int            TIMEOUT = DEF_TIMEOUT
) (
    input  logic           clk,
    input  logic           rst,
    spi_boot_seq_if.slave  bus
);

    localparam logic [AW-1:0] LAST_CNT  = AW'(WORDS - 1);
    localparam logic [15:0]   TMR_LIMIT = 16'(TIMEOUT - 1);

    state_e        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic [31:0]   word_q, word_d;

    logic          fetch_start_q, fetch_start_d;
    logic [AW-1:0] fetch_addr_q, fetch_addr_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]   mem_wdata_q, mem_wdata_d;
    logic          cpu_rst_n_q, cpu_rst_n_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          err_q, err_d;

    logic          tmr_clr;
    logic          tmr_en;
    logic          tmr_expired;

    boot_timeout_cnt #(
        .LIMIT     (TMR_LIMIT)
    ) u_timeout (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (tmr_clr),
        .en_i      (tmr_en),
        .expired_o (tmr_expired)
    );

    // -------------------------------------------------------------------------
    // Next-state and next-output logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        word_d        = word_q;
        fetch_start_d = 1'b0;
        fetch_addr_d  = fetch_addr_q;
        mem_we_d      = 1'b0;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        tmr_clr       = 1'b0;
        tmr_en        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.i_boot_req) begin
                    cnt_d   = '0;
                    state_d = ST_ISSUE;
                end
            end

            ST_ISSUE: begin
                if (bus.i_abort) begin
                    state_d = ST_IDLE;
                // Hold off while the previous word's write strobe is still
                // on the RAM port; this also keeps successive fetch
                // requests at least four cycles apart.
                end else if (!bus.i_fetch_busy && !mem_we_q) begin
                    fetch_start_d = 1'b1;
                    fetch_addr_d  = BASE + cnt_q;
                    tmr_clr       = 1'b1;
                    state_d       = ST_WAIT;
                end
            end

            ST_WAIT: begin
                if (bus.i_abort) begin
                    state_d = ST_IDLE;
                // A word arriving in the expiry cycle still counts.
                end else if (bus.i_word_valid) begin
                    word_d  = bus.i_word_data;
                    state_d = ST_WRITE;
                end else if (tmr_expired) begin
                    state_d = ST_ERR;
                end else begin
                    tmr_en = 1'b1;
                end
            end

            ST_WRITE: begin
                if (bus.i_abort) begin
                    state_d = ST_IDLE;
                end else begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = cnt_q;
                    mem_wdata_d = word_q;
                    if (cnt_q == LAST_CNT) begin
                        state_d = ST_DONE;
                    end else begin
                        cnt_d   = cnt_q + 1'b1;
                        state_d = ST_ISSUE;
                    end
                end
            end

            ST_DONE, ST_ERR: begin
                if (bus.i_boot_req) begin
                    cnt_d   = '0;
                    state_d = ST_ISSUE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d      = is_busy_state(state_d);
        err_d       = (state_d == ST_ERR);
        // Only a DONE that persists releases the CPU, which places the
        // release one cycle after the final write strobe and drops it as
        // soon as a new boot is requested.
        done_d      = (state_q == ST_DONE) && (state_d == ST_DONE);
        cpu_rst_n_d = done_d;
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            word_q        <= '0;
            fetch_start_q <= 1'b0;
            fetch_addr_q  <= '0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            cpu_rst_n_q   <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            word_q        <= word_d;
            fetch_start_q <= fetch_start_d;
            fetch_addr_q  <= fetch_addr_d;
            mem_we_q      <= mem_we_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            cpu_rst_n_q   <= cpu_rst_n_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            err_q         <= err_d;
        end
    end

    assign bus.o_fetch_start = fetch_start_q;
    assign bus.o_fetch_addr  = fetch_addr_q;
    assign bus.o_mem_we      = mem_we_q;
    assign bus.o_mem_addr    = mem_addr_q;
    assign bus.o_mem_wdata   = mem_wdata_q;
    assign bus.o_cpu_rst_n   = cpu_rst_n_q;
    assign bus.o_busy        = busy_q;
    assign bus.o_done        = done_q;
    assign bus.o_err         = err_q;

endmodule

// File: tb/tb_spi_boot_seq.sv
// -----------------------------------------------------------------------------
// tb_spi_boot_seq
// Directed bench for spi_boot_seq (WORDS=4, BASE=0x10, TIMEOUT=8).
// A per-cycle vector table covers a full load, backpressure, abort in WRITE
// and stray valids; hand-written sequences cover timeout, valid in the
// expiry cycle, restart from ERR and reset asserted mid-boot.
// -----------------------------------------------------------------------------
module tb_spi_boot_seq;

    localparam int AW = 10;

    logic clk;
    logic rst;

    spi_boot_seq_if #(.AW(AW)) bus ();

    spi_boot_seq #(
        .AW      (AW),
        .WORDS   (4),
        .BASE    (10'h010),
        .TIMEOUT (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    typedef struct packed {
        logic        boot_req;
        logic        abort;
        logic        fbusy;
        logic        wvalid;
        logic [31:0] wdata;
        logic        e_fstart;
        logic [9:0]  e_faddr;
        logic        e_we;
        logic [9:0]  e_maddr;
        logic [31:0] e_wdata;
        logic        e_rstn;
        logic        e_busy;
        logic        e_done;
        logic        e_err;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t quiet(input logic b);
        vec_t r;
        r        = '0;
        r.e_busy = b;
        return r;
    endfunction

    function automatic logic [31:0] data_of(input int w);
        return 32'hCAFE_0000 | 32'(w * 32'h0000_0101);
    endfunction

    function automatic logic [63:0] all_outs();
        return {6'd0, bus.o_fetch_start, bus.o_fetch_addr, bus.o_mem_we,
                bus.o_mem_addr, bus.o_mem_wdata, bus.o_cpu_rst_n,
                bus.o_busy, bus.o_done, bus.o_err};
    endfunction

    // Advance until a fetch pulse is visible (bounded), then check its address.
    task automatic wait_fetch(input string name, input logic [9:0] exp_addr);
        int n;
        n = 0;
        while (bus.o_fetch_start !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        chk({name, "_seen"}, 64'(bus.o_fetch_start), 64'd1);
        chk({name, "_addr"}, 64'(bus.o_fetch_addr), 64'(exp_addr));
        $display("fetch %s addr=0x%0h after %0d cycles", name, bus.o_fetch_addr, n);
    endtask

    // Called in the fetch-pulse cycle: return the word 3 cycles later and
    // check the resulting RAM write.
    task automatic serve(input int w, input logic [31:0] d, input string name);
        repeat (3) tick();
        bus.i_word_valid = 1'b1;
        bus.i_word_data  = d;
        tick();
        bus.i_word_valid = 1'b0;
        bus.i_word_data  = '0;
        chk({name, "_we_early"}, 64'(bus.o_mem_we), 64'd0);
        tick();
        chk({name, "_we"}, 64'(bus.o_mem_we), 64'd1);
        chk({name, "_waddr"}, 64'(bus.o_mem_addr), 64'(w));
        chk({name, "_wdata"}, 64'(bus.o_mem_wdata), 64'(d));
        $display("write %s addr=%0d data=0x%08h", name, bus.o_mem_addr, bus.o_mem_wdata);
    endtask

    initial begin
        vec_t v;
        logic saw_we;

        bus.i_boot_req   = 1'b0;
        bus.i_abort      = 1'b0;
        bus.i_fetch_busy = 1'b0;
        bus.i_word_valid = 1'b0;
        bus.i_word_data  = '0;
        rst              = 1'b0;

        // ---------------- vector table ----------------
        // Full load: 4 words, each returned 3 cycles after its fetch pulse.
        v = quiet(1'b1); v.boot_req = 1'b1; vecs.push_back(v);
        for (int w = 0; w < 4; w++) begin
            v = quiet(1'b1); v.e_fstart = 1'b1; v.e_faddr = 10'h010 + 10'(w); vecs.push_back(v);
            for (int k = 0; k < 3; k++) begin
                v = quiet(1'b1); vecs.push_back(v);
            end
            v = quiet(1'b1); v.wvalid = 1'b1; v.wdata = data_of(w); vecs.push_back(v);
            v = quiet(w != 3); v.e_we = 1'b1; v.e_maddr = 10'(w); v.e_wdata = data_of(w);
            vecs.push_back(v);
            if (w != 3) begin
                v = quiet(1'b1); vecs.push_back(v);
            end
        end
        // CPU released and done one cycle after the last write; a stray
        // valid in DONE writes nothing.
        v = quiet(1'b0); v.e_rstn = 1'b1; v.e_done = 1'b1; vecs.push_back(v);
        v = quiet(1'b0); v.e_rstn = 1'b1; v.e_done = 1'b1; v.wvalid = 1'b1; v.wdata = 32'h5555_AAAA;
        vecs.push_back(v);
        // Restart from DONE, then fetch engine busy for 5 ISSUE cycles.
        v = quiet(1'b1); v.boot_req = 1'b1; vecs.push_back(v);
        for (int k = 0; k < 5; k++) begin
            v = quiet(1'b1); v.fbusy = 1'b1; vecs.push_back(v);
        end
        v = quiet(1'b1); v.e_fstart = 1'b1; v.e_faddr = 10'h010; vecs.push_back(v);
        for (int k = 0; k < 3; k++) begin
            v = quiet(1'b1); vecs.push_back(v);
        end
        v = quiet(1'b1); v.wvalid = 1'b1; v.wdata = 32'h0BAD_F00D; vecs.push_back(v);
        v = quiet(1'b1); v.e_we = 1'b1; v.e_maddr = 10'd0; v.e_wdata = 32'h0BAD_F00D; vecs.push_back(v);
        v = quiet(1'b1); vecs.push_back(v);
        v = quiet(1'b1); v.e_fstart = 1'b1; v.e_faddr = 10'h011; vecs.push_back(v);
        for (int k = 0; k < 3; k++) begin
            v = quiet(1'b1); vecs.push_back(v);
        end
        v = quiet(1'b1); v.wvalid = 1'b1; v.wdata = 32'h1357_9BDF; vecs.push_back(v);
        // Abort during WRITE of word 1: no strobe, IDLE, not busy.
        v = quiet(1'b0); v.abort = 1'b1; vecs.push_back(v);
        // A valid while idle is ignored.
        v = quiet(1'b0); v.wvalid = 1'b1; v.wdata = 32'hFFFF_0000; vecs.push_back(v);
        v = quiet(1'b0); vecs.push_back(v);

        // ---------------- reset state ----------------
        tick();
        tick();
        chk("reset_outputs", all_outs(), 64'd0);
        rst = 1'b1;

        // ---------------- apply table ----------------
        for (int i = 0; i < vecs.size(); i++) begin
            bus.i_boot_req   = vecs[i].boot_req;
            bus.i_abort      = vecs[i].abort;
            bus.i_fetch_busy = vecs[i].fbusy;
            bus.i_word_valid = vecs[i].wvalid;
            bus.i_word_data  = vecs[i].wdata;
            tick();
            chk($sformatf("row%0d_status", i),
                64'({bus.o_fetch_start, bus.o_mem_we, bus.o_cpu_rst_n, bus.o_busy, bus.o_done, bus.o_err}),
                64'({vecs[i].e_fstart, vecs[i].e_we, vecs[i].e_rstn, vecs[i].e_busy, vecs[i].e_done, vecs[i].e_err}));
            if (vecs[i].e_fstart) begin
                chk($sformatf("row%0d_faddr", i), 64'(bus.o_fetch_addr), 64'(vecs[i].e_faddr));
            end
            if (vecs[i].e_we) begin
                chk($sformatf("row%0d_write", i), 64'({bus.o_mem_addr, bus.o_mem_wdata}),
                    64'({vecs[i].e_maddr, vecs[i].e_wdata}));
            end
            $display("row %0d: fstart=%b we=%b rstn=%b busy=%b done=%b err=%b",
                     i, bus.o_fetch_start, bus.o_mem_we, bus.o_cpu_rst_n,
                     bus.o_busy, bus.o_done, bus.o_err);
        end
        bus.i_boot_req   = 1'b0;
        bus.i_abort      = 1'b0;
        bus.i_fetch_busy = 1'b0;
        bus.i_word_valid = 1'b0;
        bus.i_word_data  = '0;

        // ---------------- timeout on word 2 ----------------
        bus.i_boot_req = 1'b1;
        tick();
        bus.i_boot_req = 1'b0;
        wait_fetch("to_w0", 10'h010);
        serve(0, 32'h1111_0000, "to_w0");
        wait_fetch("to_w1", 10'h011);
        serve(1, 32'h1111_0001, "to_w1");
        wait_fetch("to_w2", 10'h012);
        saw_we = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            tick();
            saw_we = saw_we | bus.o_mem_we;
        end
        chk("to_err_before_expiry", 64'(bus.o_err), 64'd0);
        tick();
        saw_we = saw_we | bus.o_mem_we;
        chk("to_err", 64'(bus.o_err), 64'd1);
        chk("to_cpu_rst_n", 64'(bus.o_cpu_rst_n), 64'd0);
        chk("to_busy", 64'(bus.o_busy), 64'd0);
        chk("to_no_write_w2", 64'(saw_we), 64'd0);
        $display("timeout: err=%b busy=%b", bus.o_err, bus.o_busy);
        // Abort has no effect in ERR.
        bus.i_abort = 1'b1;
        tick();
        bus.i_abort = 1'b0;
        chk("err_abort_ignored", 64'(bus.o_err), 64'd1);

        // ---------------- restart from ERR ----------------
        bus.i_boot_req = 1'b1;
        tick();
        bus.i_boot_req = 1'b0;
        chk("restart_err_clear", 64'(bus.o_err), 64'd0);
        chk("restart_busy", 64'(bus.o_busy), 64'd1);
        wait_fetch("rs_w0", 10'h010);

        // ---------------- valid in the expiry cycle ----------------
        repeat (7) tick();
        bus.i_word_valid = 1'b1;
        bus.i_word_data  = 32'h7777_EEEE;
        tick();
        bus.i_word_valid = 1'b0;
        bus.i_word_data  = '0;
        chk("sim_err_after_edge", 64'(bus.o_err), 64'd0);
        tick();
        chk("sim_write", 64'({bus.o_mem_we, bus.o_mem_addr, bus.o_mem_wdata}),
            64'({1'b1, 10'd0, 32'h7777_EEEE}));
        chk("sim_err", 64'(bus.o_err), 64'd0);
        $display("simultaneous: we=%b err=%b", bus.o_mem_we, bus.o_err);

        // ---------------- reset during WAIT ----------------
        wait_fetch("rst_w1", 10'h011);
        tick();
        chk("rst_pre_busy", 64'(bus.o_busy), 64'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("rst_immediate", all_outs(), 64'd0);
        bus.i_word_valid = 1'b1;
        bus.i_word_data  = 32'hABCD_1234;
        tick();
        chk("rst_hold_1", all_outs(), 64'd0);
        tick();
        chk("rst_hold_2", all_outs(), 64'd0);
        rst              = 1'b1;
        bus.i_word_valid = 1'b0;
        bus.i_word_data  = '0;
        repeat (3) tick();
        chk("rst_idle_after", all_outs(), 64'd0);
        $display("reset: outputs=0x%0h", all_outs());
        bus.i_boot_req = 1'b1;
        tick();
        bus.i_boot_req = 1'b0;
        wait_fetch("post_rst_w0", 10'h010);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
